// File: rtl/grid_access_arbiter_if.sv
// Bundle of requester-side and grid-RAM-side signals for grid_access_arbiter.
// slave = arbiter view, master = requesters plus RAM (environment) view.
interface grid_access_arbiter_if #(
    parameter int NREQ   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [NREQ-1:0]          req;
    logic [NREQ-1:0]          we_req;
    logic [NREQ-1:0]          lock_req;
    logic [NREQ*ADDR_W-1:0]   addr_req;
    logic [NREQ*DATA_W-1:0]   wdata_req;
    logic [NREQ-1:0]          gnt;
    logic [NREQ-1:0]          rvalid;
    logic signed [DATA_W-1:0] rdata;
    logic                     mem_read;
    logic                     mem_write;
    logic [ADDR_W-1:0]        mem_addr;
    logic signed [DATA_W-1:0] mem_wdata;
    logic signed [DATA_W-1:0] mem_rdata;

    modport slave (
        input  req, we_req, lock_req, addr_req, wdata_req, mem_rdata,
        output gnt, rvalid, rdata, mem_read, mem_write, mem_addr, mem_wdata
    );

    modport master (
        output req, we_req, lock_req, addr_req, wdata_req, mem_rdata,
        input  gnt, rvalid, rdata, mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/grid_access_arbiter.sv
// Round-robin arbiter giving NREQ requesters one grid-RAM access per cycle, with read-data return.
// Optional single-owner lock mode is enabled by defining GRID_ARB_LOCK_EN.
module grid_access_arbiter #(
    parameter int NREQ   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    grid_access_arbiter_if.slave bus,
    output logic [31:0]         conflict_cnt
);
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

`ifdef GRID_ARB_LOCK_EN
    typedef enum logic [0:0] {ARB = 1'b0, LOCKED = 1'b1} state_t;
`else
    typedef enum logic [0:0] {ARB = 1'b0} state_t;
`endif

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    state_t                   state_q, state_d;
    logic [IDX_W-1:0]         last_gnt_q;
    logic [IDX_W-1:0]         win_idx;
    logic [IDX_W-1:0]         cand;
    logic                     win_vld;
    logic                     win_we;
`ifdef GRID_ARB_LOCK_EN
    logic                     win_lock;
`endif
    logic [ADDR_W-1:0]        win_addr;
    logic signed [DATA_W-1:0] win_wdata;

    logic [NREQ-1:0]          gnt_p1;
    logic                     rd_p1;
    logic                     wr_p1;
    logic [ADDR_W-1:0]        addr_p1;
    logic signed [DATA_W-1:0] wdata_p1;
    logic [NREQ-1:0]          vld_p2;
    logic [31:0]              conflict_cnt_q;

    always_comb begin
        win_vld   = 1'b0;
        win_idx   = last_gnt_q;
        cand      = last_gnt_q;
        win_we    = 1'b0;
`ifdef GRID_ARB_LOCK_EN
        win_lock  = 1'b0;
`endif
        win_addr  = '0;
        win_wdata = '0;
        state_d   = state_q;

        // Walk from the farthest candidate to the nearest so (last_gnt+1) ends up with top priority.
        if (state_q == ARB) begin
            for (int i = NREQ; i >= 1; i--) begin
                cand = IDX_W'((int'(last_gnt_q) + i) % NREQ);
                if (bus.req[cand]) begin
                    win_vld = 1'b1;
                    win_idx = cand;
                end
            end
        end else begin
            win_vld = bus.req[last_gnt_q];
        end

        for (int k = 0; k < NREQ; k++) begin
            if (win_idx == IDX_W'(k)) begin
                win_we    = bus.we_req[k];
`ifdef GRID_ARB_LOCK_EN
                win_lock  = bus.lock_req[k];
`endif
                win_addr  = bus.addr_req[k*ADDR_W +: ADDR_W];
                win_wdata = $signed(bus.wdata_req[k*DATA_W +: DATA_W]);
            end
        end

`ifdef GRID_ARB_LOCK_EN
        // While locked, win_idx is the owner, so win_lock is the owner's lock hold.
        if (state_q == ARB) begin
            if (win_vld && win_lock) state_d = LOCKED;
        end else if (!win_lock) begin
            state_d = ARB;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ARB;
            last_gnt_q     <= IDX_W'(NREQ - 1);
            gnt_p1         <= '0;
            rd_p1          <= 1'b0;
            wr_p1          <= 1'b0;
            addr_p1        <= '0;
            wdata_p1       <= '0;
            vld_p2         <= '0;
            conflict_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if ($countones(bus.req) >= 2) conflict_cnt_q <= sat_inc(conflict_cnt_q);

            // Stage p1: accepted request drives the RAM strobes for one cycle.
            if (win_vld) begin
                gnt_p1     <= NREQ'(1) << win_idx;
                rd_p1      <= ~win_we;
                wr_p1      <= win_we;
                addr_p1    <= win_addr;
                wdata_p1   <= win_wdata;
                last_gnt_q <= win_idx;
            end else begin
                gnt_p1 <= '0;
                rd_p1  <= 1'b0;
                wr_p1  <= 1'b0;
            end

            // Stage p2: owner tag of a read, aligned with the RAM's returned data.
            vld_p2 <= rd_p1 ? gnt_p1 : '0;
        end
    end

    assign bus.gnt       = gnt_p1;
    assign bus.mem_read  = rd_p1;
    assign bus.mem_write = wr_p1;
    assign bus.mem_addr  = addr_p1;
    assign bus.mem_wdata = wdata_p1;
    assign bus.rvalid    = vld_p2;
    assign bus.rdata     = (|vld_p2) ? bus.mem_rdata : '0;
    assign conflict_cnt  = conflict_cnt_q;
endmodule

// File: doc/grid_access_arbiter.md
GRID_ACCESS_ARBITER -- requirements
Module: grid_access_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters (2..8).
REQ-002 Parameter ADDR_W, default 32: grid address width.
REQ-003 Parameter DATA_W, default 32: grid data width, signed cell contents (-1 = empty).
REQ-004 Port clk  input  1: the single clock; all state updates on rising edge.
REQ-005 Port reset  input  1: asynchronous, active-high reset.
REQ-006 Port req  input  NREQ: per-requester access request, level, held until granted.
REQ-007 Port we_req  input  NREQ: per-requester write (1) / read (0) select, valid with req.
REQ-008 Port addr_req  input  NREQ*ADDR_W: packed addresses, requester k at bits [k*ADDR_W +: ADDR_W].
REQ-009 Port wdata_req  input  NREQ*DATA_W: packed write data, same packing.
REQ-010 Port lock_req  input  NREQ: per-requester lock hold, used only under GRID_ARB_LOCK_EN.
REQ-011 Port gnt  output  NREQ: one-hot, registered, one-cycle pulse marking the accepted request.
REQ-012 Port rvalid  output  NREQ: one-hot, one-cycle pulse carrying read data to the owner.
REQ-013 Port rdata  output  DATA_W: read data, meaningful only while any rvalid bit is high.
REQ-014 Port mem_read, mem_write  output  1 each: strobes to the grid RAM, never both high.
REQ-015 Port mem_addr  output  ADDR_W; mem_wdata  output  DATA_W: grid RAM address/data.
REQ-016 Port mem_rdata  input  DATA_W: grid RAM read data, valid one cycle after mem_read.
REQ-017 Port conflict_cnt  output  32: saturating count of cycles with two or more req bits high.

Function
REQ-018 Arbitration is round-robin: search starts at (last_gnt+1) mod NREQ; the first requester with req high wins.
REQ-019 The arbiter issues at most one access per cycle, back-to-back, no idle cycle between grants.
REQ-020 On the edge a request wins: gnt[k]=1, mem_addr/mem_wdata take requester k's values, mem_read=!we_req[k], mem_write=we_req[k], all for exactly one cycle.
REQ-021 A requester seeing gnt[k]=1 on a cycle deasserts req or presents its next request in that cycle; the arbiter never grants the same request twice.
REQ-022 Read return: one cycle after mem_read, rvalid[k]=1 and rdata=mem_rdata; the owner tag is held in a one-deep pipeline register.
REQ-023 Writes produce no rvalid.
REQ-024 A read to an address written in the immediately preceding grant returns the written value; the arbiter relies on RAM write-first ordering and adds no bypass.
REQ-025 FSM states: ARB (normal round-robin) and LOCKED (single-owner); without GRID_ARB_LOCK_EN only ARB exists.
REQ-026 When no req bit is high: gnt=0, mem strobes=0, last_gnt unchanged.
REQ-027 conflict_cnt increments by 1 on every cycle where popcount(req)>=2, saturating at 32'hFFFFFFFF.
REQ-028 req bits above NREQ-1 do not exist; addresses pass unmodified, with no range check (the requester validates grid bounds).

Reset
REQ-029 Asserting reset at any time, including mid-read, clears gnt, rvalid, mem_read, mem_write, mem_addr, mem_wdata, rdata, conflict_cnt and the tag pipeline to 0, and forces state ARB.
REQ-030 Reset sets last_gnt=NREQ-1, so requester 0 has first priority after reset.
REQ-031 A read in flight at reset produces no rvalid after release.

Configuration
REQ-032 Macro GRID_ARB_LOCK_EN defined: if granted requester k has lock_req[k]=1 on its grant cycle, the FSM enters LOCKED. Only k is granted until a cycle with lock_req[k]=0, then the FSM returns to ARB with last_gnt=k. This supports atomic read-check-write of a grid cell.
REQ-033 Macro GRID_ARB_LOCK_EN undefined: lock_req is ignored, and the FSM stays in ARB.

Verification
REQ-034 Reset release, req=4'b1111 held -> gnt sequence 0001,0010,0100,1000,0001 on consecutive cycles; conflict_cnt=5 after 5 cycles.
REQ-035 Requester 2 reads addr 7, mem_rdata=-1 -> gnt[2] pulses with mem_read=1, mem_addr=7; next cycle rvalid=4'b0100, rdata=-1.
REQ-036 Requester 1 writes addr 12 data 3, then requester 3 reads addr 12 the next cycle -> mem_write then mem_read back-to-back; rvalid[3] with rdata=3.
REQ-037 GRID_ARB_LOCK_EN: requester 0 locks, reads addr 5, then writes addr 5; req=4'b1111 throughout -> gnt stays 0001 until lock drops, then 0010 next.
REQ-038 Reset asserted one cycle after a read grant -> no rvalid after release; all outputs 0; the first grant goes to requester 0.
REQ-039 conflict_cnt preloaded near saturation by forcing, two reqs held -> count stays at 32'hFFFFFFFF.
